// File: rtl/regfile_bus_pkg.sv
// Shared types and constants for the two-master regfile bus arbiter.
package regfile_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StHold,
    StResp
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 32;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Cycles from the IDLE sample to the ack, and cycles per complete transaction.
  localparam int unsigned ACK_LATENCY = 3;
  localparam int unsigned SLOT_CYCLES = 4;

endpackage

// File: rtl/regfile_bus_arb_rr_arb2.sv
// Two-input round-robin picker: combinational choice plus the last-grant register.
module rr_arb2
  import regfile_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       grant_idx,
  output logic       valid,
  output logic       pick
);

  logic last_q, last_d;

  always_comb begin
    valid = |req;
    // Under contention the master that did not win last time goes first.
    if (req == 2'b11) begin
      pick = ~last_q;
    end else begin
      pick = req[1];
    end
    last_d = update ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_bus_arb.sv
// Arbitrates two req/ack masters onto the regfile bus with the ACCESS/HOLD/RESP sequence.
module regfile_bus_arb
  import regfile_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  reg_en,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  arb_busy,
  output logic                  arb_owner
);

  state_e                  state_q, state_d;
  logic                    cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    owner_q, owner_d;
  logic                    reg_en_q, reg_en_d, reg_we_q, reg_we_d;
  logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
  logic                    m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                    busy_q, busy_d;

  logic                    arb_valid, arb_pick, arb_update;
  logic                    win_we;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic [DATA_WIDTH-1:0]   resp_data;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       ({m1_req, m0_req}),
    .update    (arb_update),
    .grant_idx (owner_q),
    .valid     (arb_valid),
    .pick      (arb_pick)
  );

  assign win_we    = arb_pick ? m1_we    : m0_we;
  assign win_addr  = arb_pick ? m1_addr  : m0_addr;
  assign win_wdata = arb_pick ? m1_wdata : m0_wdata;
  assign resp_data = cmd_we_q ? '0 : rdata_q;

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    owner_d     = owner_q;
    reg_en_d    = 1'b0;
    reg_we_d    = 1'b0;
    reg_addr_d  = '0;
    reg_wdata_d = '0;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rdata_d  = '0;
    m1_rdata_d  = '0;
    arb_update  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d     = StAccess;
          owner_d     = arb_pick;
          cmd_we_d    = win_we;
          cmd_addr_d  = win_addr;
          cmd_wdata_d = win_wdata;
          reg_en_d    = 1'b1;
          reg_we_d    = win_we;
          reg_addr_d  = win_addr;
          reg_wdata_d = win_wdata;
        end
      end
      StAccess: begin
        state_d = StHold;
        if (!cmd_we_q) begin
          rdata_d = reg_rdata;
        end
        // Address and data stay up for the regfile's delayed write strobe.
        reg_addr_d  = cmd_addr_q;
        reg_wdata_d = cmd_wdata_q;
      end
      StHold: begin
        state_d = StResp;
        if (owner_q == M1) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = resp_data;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = resp_data;
        end
      end
      StResp: begin
        state_d    = StIdle;
        arb_update = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      owner_q     <= 1'b0;
      reg_en_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
      owner_q     <= owner_d;
      reg_en_q    <= reg_en_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_en    = reg_en_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign arb_busy  = busy_q;
  assign arb_owner = owner_q;

endmodule

// File: doc/regfile_bus_arb.md
Name: regfile_bus_arb

Overview:
- Two-master arbiter and sequencer for the regfile bus port (reg_en/reg_we/reg_addr/reg_wdata/reg_rdata) of the GPIO configuration regfile.
- Gives each master a simple req/ack access to the regfile. Alternates grants round-robin.
- Generates the exact bus timing the regfile needs. The regfile registers its write strobe one cycle after reg_en, so reg_wdata must stay valid for one extra cycle.

Parameters:
DATA_WIDTH, 32, width of wdata/rdata on all ports
ADDR_WIDTH, 32, width of addr on all ports

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
m0_req  input  1  master 0 request; held until m0_ack
m0_we  input  1  master 0 write(1)/read(0); stable while m0_req
m0_addr  input  ADDR_WIDTH  master 0 address; stable while m0_req
m0_wdata  input  DATA_WIDTH  master 0 write data; stable while m0_req
m0_ack  output  1  one-cycle completion pulse to master 0
m0_rdata  output  DATA_WIDTH  read data, valid when m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as master 0, for master 1
reg_en  output  1  regfile access strobe
reg_we  output  1  regfile write qualifier
reg_addr  output  ADDR_WIDTH  regfile address
reg_wdata  output  DATA_WIDTH  regfile write data
reg_rdata  input  DATA_WIDTH  regfile combinational read data
arb_busy  output  1  high in any state other than IDLE
arb_owner  output  1  index of the current/last granted master

Behaviour:
- All outputs are registered. The FSM has four states: IDLE, ACCESS, HOLD, RESP.
- IDLE:
  - Samples m0_req/m1_req.
  - Only one requesting: that master wins. Both requesting: the master not equal to last_grant wins.
  - On a grant: latch we/addr/wdata from the winner into the internal cmd register, set arb_owner, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (1 cycle):
  - reg_en=1, reg_we=cmd_we, reg_addr=cmd_addr, reg_wdata=cmd_wdata.
  - Read: capture reg_rdata into rdata_q at the end of this cycle.
  - Next state: HOLD.
- HOLD (1 cycle):
  - reg_en=0, reg_we=0. reg_addr and reg_wdata keep their cmd values, so the regfile's delayed write strobe captures the correct data.
  - Next state: RESP.
- RESP (1 cycle):
  - Assert mX_ack=1 for the owner only. mX_rdata=rdata_q for reads, 0 for writes.
  - Update last_grant to the owner. Next state: IDLE.
- Latency and throughput:
  - req high in IDLE cycle T gives reg_en at T+1 and ack at T+3.
  - One transaction per 4 cycles.
- Requester rules:
  - A req still high in the IDLE cycle after its ack is a new transaction.
  - Changing we/addr/wdata while req is high and before ack has no effect after the IDLE sample (the cmd register is already latched).
- Idle/default values: reg_addr/reg_wdata are 0 in IDLE. mX_rdata is 0 except in the owner's ack cycle. A non-owner ack is never asserted.
- Unmapped addresses need no special handling. The regfile returns 0, which is passed through, and no error is signalled.
- Reset (synchronous):
  - Next edge: state=IDLE, last_grant=1 (so m0 wins the first contention).
  - All outputs 0, including arb_owner=0 and acks=0.
  - A transaction caught by reset is aborted with no ack. If reset hits ACCESS of a write, the regfile may still commit it. The master must reissue.
- A master dropping req mid-transaction (protocol violation): the transaction still completes and the ack is still issued.

Decomposition:
- Package regfile_bus_pkg holds:
  - state encoding for IDLE/ACCESS/HOLD/RESP (2-bit)
  - default DATA_WIDTH/ADDR_WIDTH
  - master index constants M0=0, M1=1
  - cycle-count constants ACK_LATENCY=3 and SLOT_CYCLES=4
- One sub-module, rr_arb2: a two-input round-robin picker (combinational choose plus last_grant register with update enable). The FSM, cmd register and bus drive stay in the top module.

Test Plan:
1. After reset, m0 writes addr 0x0 data 0xA5A5_5A5A at T:
   - reg_en=1, reg_we=1 at T+1.
   - reg_wdata=0xA5A5_5A5A at T+1 and T+2.
   - m0_ack at T+3.
   - A following m1 read of 0x0 returns m1_rdata=0xA5A5_5A5A.
2. m0 and m1 both request reads from reset:
   - m0_ack at T+3, m1_ack at T+7.
   - With both held continuously, acks alternate m0, m1, m0, m1 every 4 cycles.
3. m1 reads unmapped addr 0x4 -> m1_rdata=0x0 with m1_ack at T+3, m0_ack stays 0.
4. reset asserted during HOLD of an m1 write:
   - No m1_ack.
   - All outputs 0 on the next cycle, arb_busy=0.
   - A subsequent simultaneous m0/m1 request grants m0 first.
5. m0 holds req through its ack with m1 idle -> second m0 transaction starts in the IDLE cycle after the ack, second ack 4 cycles after the first.
6. Bench changes reg_rdata after the ACCESS cycle of an m0 read -> m0_rdata equals the value present during ACCESS, not the later value.
